// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter block.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    // Both 00 and 11 mean "no parity bit in the frame".
    function automatic logic parity_enabled(input parity_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake into the transmitter FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;

    modport master (output tx_data_i, output tx_valid_i, input  tx_ready_o);
    modport slave  (input  tx_data_i, input  tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_o = (wr_ptr == rd_ptr);
    assign count_o = wr_ptr - rd_ptr;
    assign dout_o  = mem[rd_ptr[AW-1:0]];

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din_i;
    end

    // Pointer update; reset discards all contents.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: FIFO-buffered words serialised as start, data (LSB
// first), optional parity and 1/2 stop bits. Frame settings are latched
// when a word is popped so mid-frame config changes only hit later frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    uart_tx_fifo_if.slave                 tx_if,
    output logic                          tx_o,
    output logic                          busy_o,
    input  logic [DIV_W-1:0]              baudrate_i,
    input  logic [1:0]                    parity_mode_i,
    input  logic                          stopbit_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int BW = $clog2(DATA_W);

    tx_state_t         state;
    logic [DIV_W-1:0]  cnt, n_q;
    logic [DATA_W-1:0] shift;
    logic [BW-1:0]     bit_idx;
    logic              par_en_q, par_bit_q, two_stop_q, stop_idx_q;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, pop;
    logic              baud_done, last_stop, line;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_if.tx_valid_i),
        .din_i   (tx_if.tx_data_i),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    assign tx_if.tx_ready_o = !fifo_full;

    assign baud_done = (cnt == n_q - 1'b1);
    assign last_stop = !two_stop_q || stop_idx_q;
    // Pop from IDLE, or on the final stop-bit edge so frames run gap-free.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && baud_done && last_stop));

    // Line level implied by the current state; registered into tx_o.
    always_comb begin
        line = 1'b1;
        case (state)
            START:   line = 1'b0;
            DATA:    line = shift[0];
            PARITY:  line = par_bit_q;
            default: line = 1'b1;
        endcase
    end

    // Frame FSM with baud counter, shifter and registered line/busy outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            n_q        <= DIV_W'(1);
            shift      <= '0;
            bit_idx    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            // busy_o lags state by one cycle, like tx_o, so it covers the
            // whole visible frame on the line.
            tx_o   <= line;
            busy_o <= (state != IDLE) || !fifo_empty;
            if (pop) begin
                state      <= START;
                cnt        <= '0;
                shift      <= fifo_dout;
                n_q        <= (baudrate_i == '0) ? DIV_W'(1) : baudrate_i;
                par_en_q   <= parity_enabled(parity_mode_t'(parity_mode_i));
                par_bit_q  <= (parity_mode_t'(parity_mode_i) == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
                two_stop_q <= (stopbit_i == STOP_TWO);
            end else begin
                case (state)
                    START: begin
                        if (baud_done) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else cnt <= cnt + 1'b1;
                    end
                    DATA: begin
                        if (baud_done) begin
                            cnt   <= '0;
                            shift <= shift >> 1;
                            if (bit_idx == BW'(DATA_W - 1)) begin
                                stop_idx_q <= 1'b0;
                                state      <= par_en_q ? PARITY : STOP;
                            end else bit_idx <= bit_idx + 1'b1;
                        end else cnt <= cnt + 1'b1;
                    end
                    PARITY: begin
                        if (baud_done) begin
                            cnt        <= '0;
                            stop_idx_q <= 1'b0;
                            state      <= STOP;
                        end else cnt <= cnt + 1'b1;
                    end
                    STOP: begin
                        if (baud_done) begin
                            cnt <= '0;
                            if (last_stop) state <= IDLE;
                            else           stop_idx_q <= 1'b1;
                        end else cnt <= cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line traces compared against a frame model.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tx, busy, sb;
    logic [DIVW-1:0] baud;
    logic [1:0]      pm;
    logic [3:0]      cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic obs[$];
    logic exp_q[$];

    uart_tx_fifo_if #(.DATA_W(DW)) tx_if ();

    uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIVW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tx_if         (tx_if),
        .tx_o          (tx),
        .busy_o        (busy),
        .baudrate_i    (baud),
        .parity_mode_i (pm),
        .stopbit_i     (sb),
        .fifo_count_o  (cnt)
    );

    always #5 clk = ~clk;

    // Reference: list the frame's bit levels, then hold each for N cycles.
    task automatic add_frame(input logic [DW-1:0] d, input int n, input logic [1:0] mode,
                             input logic two);
        int   ne;
        logic bits[$];
        ne = (n == 0) ? 1 : n;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (mode == 2'b01) bits.push_back(^d);
        if (mode == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[i]) repeat (ne) exp_q.push_back(bits[i]);
    endtask

    task automatic capture(input int n);
        repeat (n) begin
            @(negedge clk);
            obs.push_back(tx);
        end
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        @(negedge clk);
        tx_if.tx_valid_i = 1'b1;
        tx_if.tx_data_i  = d;
        @(posedge clk);
        #1 tx_if.tx_valid_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [DIVW-1:0] b, input logic [1:0] m, input logic s);
        @(negedge clk);
        baud = b; pm = m; sb = s;
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (tx_if.tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", tx_if.tx_ready_o); end
        n_cmp++; if (cnt !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt); end
    endtask

    task automatic test_basic;
        int bad_at;
        set_cfg(16'd4, 2'b00, 1'b0);
        add_frame(8'hA5, 4, 2'b00, 1'b0);
        push_one(8'hA5);
        repeat (2) @(negedge clk);
        capture(exp_q.size());
        bad_at = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad_at < 0 && obs[i] !== exp_q[i]) bad_at = i;
        n_cmp++; if (bad_at >= 0) begin n_bad++; $display("FAIL basic_trace: cycle %0d got %b want %b", bad_at, obs[bad_at], exp_q[bad_at]); end
        n_cmp++; if (exp_q.size() != 40) begin n_bad++; $display("FAIL basic_len: got %0d want 40", exp_q.size()); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_stop: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_bad++; $display("FAIL basic_busy_drop: busy %b tx %b want 0 1", busy, tx); end
    endtask

    task automatic test_parity;
        logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b00};
        int         ns    [3] = '{3, 3, 2};
        logic       stops [3] = '{1'b0, 1'b0, 1'b1};
        logic       want_par [2] = '{1'b1, 1'b0};
        int bad_at;
        for (int t = 0; t < 3; t++) begin
            set_cfg(DIVW'(ns[t]), modes[t], stops[t]);
            add_frame(8'h07, ns[t], modes[t], stops[t]);
            push_one(8'h07);
            repeat (2) @(negedge clk);
            capture(exp_q.size());
            bad_at = -1;
            for (int i = 0; i < exp_q.size(); i++) if (bad_at < 0 && obs[i] !== exp_q[i]) bad_at = i;
            n_cmp++; if (bad_at >= 0) begin n_bad++; $display("FAIL parity_trace%0d: cycle %0d got %b want %b", t, bad_at, obs[bad_at], exp_q[bad_at]); end
            if (t < 2) begin
                n_cmp++; if (obs[9*ns[t]] !== want_par[t]) begin n_bad++; $display("FAIL parity_bit%0d: got %b want %b", t, obs[9*ns[t]], want_par[t]); end
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_baud_zero;
        int bad_at;
        set_cfg(16'd0, 2'b00, 1'b0);
        add_frame(8'h3C, 0, 2'b00, 1'b0);
        push_one(8'h3C);
        repeat (2) @(negedge clk);
        capture(exp_q.size() + 2);
        bad_at = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad_at < 0 && obs[i] !== exp_q[i]) bad_at = i;
        n_cmp++; if (bad_at >= 0) begin n_bad++; $display("FAIL baud0_trace: cycle %0d got %b want %b", bad_at, obs[bad_at], exp_q[bad_at]); end
        n_cmp++; if (obs[10] !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL baud0_end: tx %b busy %b want 1 0", obs[10], busy); end
    endtask

    task automatic test_config_latch;
        int bad_at;
        set_cfg(16'd4, 2'b00, 1'b0);
        add_frame(8'h5A, 4, 2'b00, 1'b0);
        add_frame(8'hC3, 8, 2'b00, 1'b0);
        push_one(8'h5A);
        push_one(8'hC3);
        @(negedge clk);
        fork
            capture(exp_q.size());
            begin repeat (10) @(negedge clk); baud = 16'd8; end
        join
        bad_at = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad_at < 0 && obs[i] !== exp_q[i]) bad_at = i;
        n_cmp++; if (bad_at >= 0) begin n_bad++; $display("FAIL latch_trace: cycle %0d got %b want %b", bad_at, obs[bad_at], exp_q[bad_at]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random;
        logic [DW-1:0] d;
        int n, bad_at;
        logic [1:0] m;
        logic s;
        for (int t = 0; t < 6; t++) begin
            d = DW'($urandom); n = $urandom_range(0, 5);
            m = 2'($urandom_range(0, 3)); s = 1'($urandom_range(0, 1));
            set_cfg(DIVW'(n), m, s);
            add_frame(d, n, m, s);
            push_one(d);
            repeat (2) @(negedge clk);
            capture(exp_q.size());
            bad_at = -1;
            for (int i = 0; i < exp_q.size(); i++) if (bad_at < 0 && obs[i] !== exp_q[i]) bad_at = i;
            n_cmp++; if (bad_at >= 0) begin n_bad++; $display("FAIL rand%0d_trace d=%h n=%0d m=%0d s=%0d: cycle %0d got %b want %b", t, d, n, m, s, bad_at, obs[bad_at], exp_q[bad_at]); end
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rand%0d_busy: got %b want 0", t, busy); end
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] w [10];
        int bad_at;
        for (int i = 0; i < 10; i++) w[i] = DW'($urandom);
        set_cfg(16'd16, 2'b00, 1'b0);
        for (int i = 0; i < 9; i++) add_frame(w[i], 16, 2'b00, 1'b0);
        @(negedge clk);
        tx_if.tx_valid_i = 1'b1; tx_if.tx_data_i = w[0];
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i <= 9; i++) begin
                    @(negedge clk);
                    if (i == 8) begin
                        n_cmp++; if (cnt !== 4'd7 || tx_if.tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_cnt7: count %0d ready %b want 7 1", cnt, tx_if.tx_ready_o); end
                    end
                    if (i == 9) begin
                        n_cmp++; if (cnt !== 4'd8 || tx_if.tx_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_full: count %0d ready %b want 8 0", cnt, tx_if.tx_ready_o); end
                    end
                    tx_if.tx_data_i = w[i];
                    @(posedge clk);
                end
                @(negedge clk);
                tx_if.tx_valid_i = 1'b0;
                n_cmp++; if (cnt !== 4'd8) begin n_bad++; $display("FAIL b2b_tenth: count %0d want 8", cnt); end
            end
            begin repeat (2) @(negedge clk); capture(exp_q.size()); end
        join
        bad_at = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad_at < 0 && obs[i] !== exp_q[i]) bad_at = i;
        n_cmp++; if (bad_at >= 0) begin n_bad++; $display("FAIL b2b_trace: cycle %0d got %b want %b", bad_at, obs[bad_at], exp_q[bad_at]); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_pop;
        logic [DW-1:0] w [9];
        int bad_at;
        for (int i = 0; i < 9; i++) w[i] = DW'($urandom);
        set_cfg(16'd1, 2'b00, 1'b0);
        for (int i = 0; i < 9; i++) add_frame(w[i], 1, 2'b00, 1'b0);
        repeat (10) exp_q.push_back(1'b1);
        @(negedge clk);
        tx_if.tx_valid_i = 1'b1; tx_if.tx_data_i = w[0];
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i < 9; i++) begin
                    @(negedge clk); tx_if.tx_data_i = w[i]; @(posedge clk);
                end
                @(negedge clk);
                tx_if.tx_data_i = 8'hEE;
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk); @(negedge clk);
                    if (cnt != 4'd8) break;
                end
                tx_if.tx_valid_i = 1'b0;
                n_cmp++; if (cnt !== 4'd7) begin n_bad++; $display("FAIL fullpop_count: got %0d want 7", cnt); end
            end
            begin repeat (2) @(negedge clk); capture(exp_q.size()); end
        join
        bad_at = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad_at < 0 && obs[i] !== exp_q[i]) bad_at = i;
        n_cmp++; if (bad_at >= 0) begin n_bad++; $display("FAIL fullpop_trace: cycle %0d got %b want %b", bad_at, obs[bad_at], exp_q[bad_at]); end
    endtask

    task automatic test_reset_mid;
        int stray;
        set_cfg(16'd4, 2'b00, 1'b0);
        push_one(8'h00);
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        repeat (12) @(negedge clk);
        n_cmp++; if (tx !== 1'b0 || cnt !== 4'd3) begin n_bad++; $display("FAIL midrst_pre: tx %b count %0d want 0 3", tx, cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1 || cnt !== 4'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_async: tx %b count %0d busy %b want 1 0 0", tx, cnt, busy); end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL midrst_after: %0d active cycles want 0", stray); end
    endtask

    initial begin
        tx_if.tx_valid_i = 1'b0;
        tx_if.tx_data_i  = '0;
        baud = 16'd4; pm = 2'b00; sb = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_baud_zero();
        test_config_latch();
        test_random();
        test_back_to_back();
        test_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
